// File: rtl/uart_pkg.sv
// Shared constants and state type for the UART receive path.
// Used by uart_receiver and uart_rx_sync.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input pin.
// Synchronous reset loads 1 so a reset never looks like a start bit.
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_ff1;
    logic r_ff2;

    // Two-stage capture of the raw pin
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ff1 <= 1'b1;
            r_ff2 <= 1'b1;
        end else begin
            r_ff1 <= i_d;
            r_ff2 <= r_ff1;
        end
    end

    assign o_q = r_ff2;

endmodule

// File: rtl/uart_receiver.sv
// 16x oversampled UART receiver: 8N1, or 8E1/8O1 with UART_RX_PARITY_EN.
// Samples mid-bit, reports byte plus frame/parity flags with a 1-cycle strobe.
module uart_receiver
    import uart_pkg::*;
#(
    parameter logic PARITY_MODE = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rxd,
    output logic [7:0] o_data_out,
    output logic       o_data_valid,
    output logic       o_frame_error,
    output logic       o_parity_error,
    output logic       o_busy
);

    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID       = 4'(MID_TICK);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    logic                 w_rxd_s;
    rx_state_t            r_state;
    logic [3:0]           r_tick;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shreg;
    logic [7:0]           r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_busy;
`ifdef UART_RX_PARITY_EN
    logic                 r_perr;
    logic                 r_perr_out;
`endif

    uart_rx_sync u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rxd),
        .o_q   (w_rxd_s)
    );

    // Frame FSM with bit timing, shifting and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_tick     <= '0;
            r_bit_idx  <= '0;
            r_shreg    <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
            r_busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr     <= 1'b0;
            r_perr_out <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (!w_rxd_s) begin
                        r_state <= START;
                        r_tick  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (r_tick == MID) begin
                        r_tick <= '0;
                        if (!w_rxd_s) begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_tick <= r_tick + 4'd1;
                    end
                end
                DATA: begin
                    r_tick <= r_tick + 4'd1;
                    if (r_tick == LAST_TICK) begin
                        r_shreg   <= {w_rxd_s, r_shreg[DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    r_tick <= r_tick + 4'd1;
                    if (r_tick == LAST_TICK) begin
                        r_perr  <= ^r_shreg ^ w_rxd_s ^ PARITY_MODE;
                        r_state <= STOP;
                    end
                end
`endif
                STOP: begin
                    r_tick <= r_tick + 4'd1;
                    if (r_tick == LAST_TICK) begin
                        // Leave mid-stop-bit so a back-to-back start is caught
                        r_data  <= r_shreg;
                        r_valid <= 1'b1;
                        r_ferr  <= ~w_rxd_s;
`ifdef UART_RX_PARITY_EN
                        r_perr_out <= r_perr;
`endif
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_data_out    = r_data;
    assign o_data_valid  = r_valid;
    assign o_frame_error = r_ferr;
    assign o_busy        = r_busy;
`ifdef UART_RX_PARITY_EN
    assign o_parity_error = r_perr_out;
`else
    // No parity bit on the wire, so the parity sense has no effect
    assign o_parity_error = PARITY_MODE & 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed + random bench for uart_receiver.
// Follows UART_RX_PARITY_EN to build frames of the matching length.
module tb_uart_receiver;

`ifdef UART_RX_PARITY_EN
    localparam int PEXTRA = 16;
    localparam bit HAS_PAR = 1'b1;
`else
    localparam int PEXTRA = 0;
    localparam bit HAS_PAR = 1'b0;
`endif
    localparam bit MODE = 1'b0;
    // pin start edge to strobe cycle: 2 sync + 1 detect + 152 to stop sample
    localparam int LAT = 155 + PEXTRA;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] dout;
    logic       dv, fe, pe, busy;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int         c;
        logic [7:0] d;
        logic       fe;
        logic       pe;
        logic       busy;
    } ev_t;
    ev_t q[$];

    uart_receiver #(.PARITY_MODE(MODE)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_rxd          (rxd),
        .o_data_out     (dout),
        .o_data_valid   (dv),
        .o_frame_error  (fe),
        .o_parity_error (pe),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dv === 1'b1) begin
            q.push_back('{c: cyc, d: dout, fe: fe, pe: pe, busy: busy});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic good_par(input logic [7:0] b);
        // parity bit making the count of ones even (MODE 0) or odd (MODE 1)
        return logic'(($countones(b) % 2) != int'(MODE));
    endfunction

    function automatic logic exp_perr(input logic [7:0] b, input logic pb);
        if (!HAS_PAR) return 1'b0;
        return logic'((($countones(b) + int'(pb)) % 2) != int'(MODE));
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic pb,
                              input logic sb, output int s);
        s = cyc;
        rxd = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (16) @(posedge clk);
            #1;
        end
        if (HAS_PAR) begin
            rxd = pb;
            repeat (16) @(posedge clk);
            #1;
        end
        rxd = sb;
        repeat (16) @(posedge clk);
        #1;
        rxd = 1'b1;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d,
                               input logic efe, input logic epe,
                               input int ecyc);
        ev_t e;
        chk({tag, "_present"}, 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk({tag, "_data"}, 32'(e.d), 32'(d));
            chk({tag, "_ferr"}, 32'(e.fe), 32'(efe));
            chk({tag, "_perr"}, 32'(e.pe), 32'(epe));
            chk({tag, "_cycle"}, 32'(e.c), 32'(ecyc));
            chk({tag, "_busy"}, 32'(e.busy), 32'd0);
        end
    endtask

    initial begin
        int s, s2;
        logic [7:0] b;
        logic pb, sb;

        // reset state
        repeat (5) @(posedge clk);
        #1;
        chk("rst_data", 32'(dout), 32'h0);
        chk("rst_valid", 32'(dv), 32'h0);
        chk("rst_ferr", 32'(fe), 32'h0);
        chk("rst_perr", 32'(pe), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        idle(10);

        // clean 0xA5
        send_frame(8'hA5, good_par(8'hA5), 1'b1, s);
        check_frame("a5", 8'hA5, 1'b0, 1'b0, s + LAT);
        idle(30);
        chk("a5_hold", 32'(dout), 32'hA5);

        // 4-cycle glitch
        s = cyc;
        rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("glitch_busy_hi", 32'(busy), 32'd1);
        repeat (30) @(posedge clk);
        #1;
        chk("glitch_busy_lo", 32'(busy), 32'd0);
        chk("glitch_no_valid", 32'(q.size()), 32'd0);

        // bad stop then clean frame
        send_frame(8'h3C, good_par(8'h3C), 1'b0, s);
        check_frame("3c", 8'h3C, 1'b1, 1'b0, s + LAT);
        idle(30);
        chk("3c_extra", 32'(q.size()), 32'd0);
        send_frame(8'h55, good_par(8'h55), 1'b1, s);
        check_frame("55", 8'h55, 1'b0, 1'b0, s + LAT);
        idle(20);

        // back-to-back
        send_frame(8'h00, good_par(8'h00), 1'b1, s);
        send_frame(8'hFF, good_par(8'hFF), 1'b1, s2);
        chk("b2b_gap", 32'(s2 - s), 32'd160 + 32'(PEXTRA));
        check_frame("b2b0", 8'h00, 1'b0, 1'b0, s + LAT);
        check_frame("b2b1", 8'hFF, 1'b0, 1'b0, s2 + LAT);
        idle(20);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, s);
        check_frame("par_ok", 8'h07, 1'b0, exp_perr(8'h07, 1'b1), s + LAT);
        idle(20);
        send_frame(8'h07, 1'b0, 1'b1, s);
        check_frame("par_bad", 8'h07, 1'b0, exp_perr(8'h07, 1'b0), s + LAT);
        idle(20);
`endif

        // reset mid-frame; bits after the reset point are all 1
        fork
            send_frame(8'hF8, good_par(8'hF8), 1'b1, s);
            begin
                repeat (72) @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                chk("mrst_data", 32'(dout), 32'h0);
                chk("mrst_busy", 32'(busy), 32'h0);
                chk("mrst_valid", 32'(dv), 32'h0);
                chk("mrst_ferr", 32'(fe), 32'h0);
                rst = 1'b0;
            end
        join
        idle(30);
        chk("mrst_no_valid", 32'(q.size()), 32'd0);
        send_frame(8'h5A, good_par(8'h5A), 1'b1, s);
        check_frame("post_rst", 8'h5A, 1'b0, 1'b0, s + LAT);
        idle(20);

        // break: line held low
        s = cyc;
        rxd = 1'b0;
        repeat (320) @(posedge clk);
        #1;
        idle(250);
        check_frame("brk0", 8'h00, 1'b1, exp_perr(8'h00, 1'b0), s + LAT);
        check_frame("brk1", 8'h00, 1'b1, exp_perr(8'h00, 1'b0),
                    s + LAT + 153 + PEXTRA);
        q.delete();
        idle(20);

        // random frames
        for (int i = 0; i < 6; i++) begin
            b  = 8'($urandom);
            sb = ($urandom_range(0, 3) != 0);
            pb = good_par(b) ^ ($urandom_range(0, 3) == 0);
            send_frame(b, pb, sb, s);
            check_frame($sformatf("rnd%0d", i), b, ~sb, exp_perr(b, pb),
                        s + LAT);
            idle(30);
            chk($sformatf("rnd%0d_extra", i), 32'(q.size()), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver, the receive-side counterpart of the team's `Transmitter`. Frame format: 1 start bit (0), 8 data bits LSB first, an optional even/odd parity bit, and 1 stop bit (1). `clk` runs at 16× the baud rate, the same oversampling clock that drives `Transmitter`. The block sits between the board RXD pin and the UART-to-SRAM loader and delivers one byte per frame with a single-cycle valid strobe.

## Interface
- `PARITY_MODE`, default 1'b0: parity sense, 0 = even, 1 = odd. Used only when `UART_RX_PARITY_EN` is defined.
- `clk`  in  1  16× baud clock, the single clock of the block.
- `rst`  in  1  synchronous, active-high reset.
- `rxd`  in  1  asynchronous serial input; idles high.
- `data_out`  out  8  last received byte; held until the next frame completes.
- `data_valid`  out  1  one-cycle pulse when `data_out` and the error flags update.
- `frame_error`  out  1  stop bit was sampled 0; updates with `data_valid`.
- `parity_error`  out  1  parity mismatch; updates with `data_valid`; tied 0 when parity is compiled out.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `rxd` passes through a 2-FF synchronizer (reset value 1). All logic uses `rxd_s`.
- Counters:
  - `tick`: 4 bits, counts 0..15 within a bit, wraps modulo 16.
  - `bit_idx`: 3 bits.
  - `shreg`: 8 bits, shifts right, new bit enters at [7].
- States:
  - **IDLE**: when `rxd_s` = 0, go to START with `tick` = 0.
  - **START**: at `tick` = 7 (mid-bit), sample `rxd_s`. If 0, go to DATA with `tick` = 0 and `bit_idx` = 0. If 1, this is a glitch: return to IDLE with no output.
  - **DATA**: at `tick` = 15, shift `rxd_s` into `shreg` and increment `bit_idx`. After `bit_idx` = 7 is sampled, go to PARITY if it is compiled in, otherwise STOP.
  - **PARITY**: at `tick` = 15, compute `perr = ^shreg ^ rxd_s ^ PARITY_MODE`, then go to STOP.
  - **STOP**: at `tick` = 15, load `data_out` from `shreg`, pulse `data_valid`, set `frame_error` to the inverse of `rxd_s`, set `parity_error` to `perr`, then go to IDLE immediately (mid-stop-bit) so that back-to-back frames are accepted.
- A byte is always delivered, even when an error flag is set; the consumer decides whether to drop it.
- Break condition (`rxd` held low): each frame period produces `data_out` = 0x00 with `frame_error` = 1. After each report, IDLE re-detects low and starts a new frame.
- `rxd` changes outside the sample points are ignored. There is no majority voting.

## Timing
- Reset values:
  - `data_out` = 0x00; `data_valid`, `frame_error`, `parity_error`, `busy` = 0.
  - State = IDLE; `tick`, `bit_idx`, `shreg` = 0; synchronizer FFs = 1.
- Edge numbering: edge E0 is the clock edge at which IDLE sees `rxd_s` low. `busy` is high from the cycle after E0.
- Sample points:
  - Start bit: E8.
  - Data bit k: E(24+16k).
  - Parity: E152.
  - Stop: E152 without parity, E168 with parity.
- `data_valid` is high for exactly the one cycle after the stop sample edge. `busy` is 0 in that same cycle.
- Pin-to-`rxd_s` latency is 2 cycles.
- `rst` asserted mid-frame: the block returns to reset values on that edge and produces no partial `data_valid`. After release, the block waits in IDLE for the next low level.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined**: the PARITY state exists, the frame is 11 bits, and `parity_error` is live.
- **Undefined**: the PARITY state and parity logic are removed, the frame is 10 bits, `PARITY_MODE` is unused, and `parity_error` is constant 0.

## Structure
- Package `uart_pkg` holds:
  - `OVERSAMPLE` = 16, `MID_TICK` = 7, `DATA_BITS` = 8.
  - State enum `rx_state_t` {IDLE, START, DATA, PARITY, STOP}.
- Sub-module `uart_rx_sync`: 2-FF synchronizer with synchronous reset to 1. Reusable for other asynchronous pins.

## Test plan
- Send 0xA5 at 16 clk/bit with a valid stop -> one `data_valid` pulse at E152, `data_out` = 0xA5, `frame_error` = 0, `busy` low again in the same cycle.
- 4-cycle low glitch on an idle line -> START aborts at E8; no `data_valid`; `busy` drops.
- Frame 0x3C with stop bit driven 0 -> `data_out` = 0x3C, `frame_error` = 1; the following clean frame 0x55 clears `frame_error`.
- Back-to-back frames 0x00 then 0xFF with no idle gap -> two `data_valid` pulses 160 cycles apart with the correct bytes.
- `UART_RX_PARITY_EN`, `PARITY_MODE` = 0: 0x07 with parity bit 1 -> `parity_error` = 0; the same byte with parity bit 0 -> `parity_error` = 1; `data_valid` at E168.
- `rst` pulsed at E70 mid-frame -> all outputs return to 0 and no `data_valid`; a frame sent after release receives correctly.
